// File: rtl/fcpu_pkg.sv
// Shared CPU definitions: datapath widths, opcodes and memory-port request classes.
// The memory classes let the port arbiter decode an MFU opcode in one place.
package fcpu_pkg;

    localparam int DATA_W   = 32;
    localparam int INSTR_W  = 6;
    localparam int RSV_ID_W = 4;
    localparam int CDB_W    = RSV_ID_W + DATA_W;
    localparam int IO_W     = 8;

    localparam logic [INSTR_W-1:0] I_NOP    = 6'd0;
    localparam logic [INSTR_W-1:0] I_ADD    = 6'd1;
    localparam logic [INSTR_W-1:0] I_SUB    = 6'd2;
    localparam logic [INSTR_W-1:0] I_LOAD   = 6'd16;
    localparam logic [INSTR_W-1:0] I_LOADB  = 6'd17;
    localparam logic [INSTR_W-1:0] I_LOADR  = 6'd18;
    localparam logic [INSTR_W-1:0] I_STORE  = 6'd19;
    localparam logic [INSTR_W-1:0] I_STOREB = 6'd20;
    localparam logic [INSTR_W-1:0] I_STORER = 6'd21;
    localparam logic [INSTR_W-1:0] I_INPUT  = 6'd22;
    localparam logic [INSTR_W-1:0] I_OUTPUT = 6'd23;

    typedef enum logic [2:0] {
        MC_NONE,
        MC_RAM_LD,
        MC_RAM_ST,
        MC_IO_IN,
        MC_IO_OUT
    } mem_class_t;

    typedef enum logic {
        GRANT_FETCH,
        GRANT_MFU
    } grant_t;

    function automatic mem_class_t mem_class(input logic [INSTR_W-1:0] opcode);
        mem_class_t cls;
        case (opcode)
            I_LOAD, I_LOADB, I_LOADR:    cls = MC_RAM_LD;
            I_STORE, I_STOREB, I_STORER: cls = MC_RAM_ST;
            I_INPUT:                     cls = MC_IO_IN;
            I_OUTPUT:                    cls = MC_IO_OUT;
            default:                     cls = MC_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/fifo.sv
// Small synchronous FIFO with a registered head; no write-to-read bypass, so
// an entry becomes visible on the output the cycle after it is pushed.
module fifo #(
    parameter int FIFO_DEPTH_W = 1,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    output logic              b_valid_o,
    output logic [DATA_W-1:0] b_data_o,
    input  logic              b_ready_i
);

    localparam int DEPTH = 1 << FIFO_DEPTH_W;

    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [FIFO_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_W:0]   cnt_q, cnt_d;
    logic                    push, pop;

    always_comb begin
        a_ready_o = (cnt_q != (FIFO_DEPTH_W+1)'(DEPTH));
        b_valid_o = (cnt_q != '0);
        b_data_o  = mem_q[rd_ptr_q];
        push      = a_valid_i && a_ready_o;
        pop       = b_valid_o && b_ready_i;
        wr_ptr_d  = push ? wr_ptr_q + FIFO_DEPTH_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + FIFO_DEPTH_W'(1) : rd_ptr_q;
        cnt_d     = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (FIFO_DEPTH_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (FIFO_DEPTH_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= a_data_i;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data RAM and byte I/O channel between instruction fetch
// and the MFU; load/input results return on the CDB in MFU acceptance order.
module mem_port_arbiter
    import fcpu_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int RESP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                f_valid,
    input  logic [DATA_W-1:0]   f_address,
    output logic                f_ready,
    output logic                f_rdata_valid,
    output logic [DATA_W-1:0]   f_rdata,
    input  logic                m_valid,
    input  logic [INSTR_W-1:0]  m_opcode,
    input  logic [RSV_ID_W-1:0] m_rsv_id,
    input  logic [DATA_W-1:0]   m_address,
    input  logic [DATA_W-1:0]   m_data,
    output logic                m_ready,
    output logic [CDB_W-1:0]    o_cdb,
    output logic                o_cdb_valid,
    input  logic                o_cdb_ready,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    input  logic                io_in_valid,
    input  logic [IO_W-1:0]     io_in_data,
    output logic                io_in_ready,
    output logic                io_out_valid,
    output logic [IO_W-1:0]     io_out_data,
    input  logic                io_out_ready
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1) + 1;

    grant_t                last_grant_q, last_grant_d;
    logic                  fetch_pend_q, fetch_pend_d;
    logic                  push_vld_q, push_vld_d;
    logic                  push_ram_q, push_ram_d;
    logic [RSV_ID_W-1:0]   push_tag_q, push_tag_d;
    logic [IO_W-1:0]       push_io_q, push_io_d;
    logic [CNT_W-1:0]      buf_cnt_q, buf_cnt_d;

    mem_class_t            m_class;
    logic                  credit_ok;
    logic                  mfu_elig, mfu_needs_ram;
    logic                  fetch_req, mfu_ram_req, contested;
    logic                  mfu_wins_ram, fetch_grant, mfu_accept;
    logic                  cdb_pop;
    logic [CDB_W-1:0]      push_data;
    logic                  fifo_a_ready, fifo_b_valid;
    logic [CDB_W-1:0]      fifo_b_data;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{f_address[DATA_W-1:ADDR_W], m_address[DATA_W-1:ADDR_W]};

    // Credits count reads in flight plus buffered results; a pop this cycle frees nothing yet.
    always_comb begin
        m_class       = mem_class(m_opcode);
        credit_ok     = (CNT_W'(push_vld_q) + buf_cnt_q) < CNT_W'(RESP_DEPTH);
        mfu_elig      = 1'b0;
        mfu_needs_ram = 1'b0;
        case (m_class)
            MC_RAM_LD: begin
                mfu_elig      = credit_ok;
                mfu_needs_ram = 1'b1;
            end
            MC_RAM_ST: begin
                mfu_elig      = 1'b1;
                mfu_needs_ram = 1'b1;
            end
            MC_IO_IN:  mfu_elig = io_in_valid && credit_ok;
            MC_IO_OUT: mfu_elig = io_out_ready;
            default:   mfu_elig = 1'b1;
        endcase
        fetch_req    = f_valid && !rst;
        mfu_ram_req  = m_valid && !rst && mfu_elig && mfu_needs_ram;
        contested    = fetch_req && mfu_ram_req;
        mfu_wins_ram = mfu_ram_req && (!fetch_req || last_grant_q == GRANT_FETCH);
        fetch_grant  = fetch_req && !mfu_wins_ram;
        mfu_accept   = m_valid && !rst && mfu_elig && (!mfu_needs_ram || mfu_wins_ram);
        cdb_pop      = fifo_b_valid && o_cdb_ready;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (contested) begin
            last_grant_d = mfu_wins_ram ? GRANT_MFU : GRANT_FETCH;
        end
        fetch_pend_d = fetch_grant;
        push_vld_d   = mfu_accept && (m_class == MC_RAM_LD || m_class == MC_IO_IN);
        push_ram_d   = (m_class == MC_RAM_LD);
        push_tag_d   = m_rsv_id;
        push_io_d    = io_in_data;
        buf_cnt_d    = buf_cnt_q;
        case ({push_vld_q, cdb_pop})
            2'b10:   buf_cnt_d = buf_cnt_q + CNT_W'(1);
            2'b01:   buf_cnt_d = buf_cnt_q - CNT_W'(1);
            default: buf_cnt_d = buf_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_FETCH;
            fetch_pend_q <= 1'b0;
            push_vld_q   <= 1'b0;
            buf_cnt_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            fetch_pend_q <= fetch_pend_d;
            push_vld_q   <= push_vld_d;
            buf_cnt_q    <= buf_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        push_ram_q <= push_ram_d;
        push_tag_q <= push_tag_d;
        push_io_q  <= push_io_d;
    end

    always_comb begin
        f_ready       = fetch_grant;
        f_rdata_valid = fetch_pend_q;
        f_rdata       = fetch_pend_q ? ram_rdata : '0;
        m_ready       = mfu_accept;
        ram_en        = fetch_grant || (mfu_accept && mfu_needs_ram);
        ram_we        = mfu_accept && (m_class == MC_RAM_ST);
        ram_addr      = '0;
        if (mfu_accept && mfu_needs_ram) begin
            ram_addr = m_address[ADDR_W-1:0];
        end else if (fetch_grant) begin
            ram_addr = f_address[ADDR_W-1:0];
        end
        ram_wdata     = ram_we ? m_data : '0;
        io_in_ready   = mfu_accept && (m_class == MC_IO_IN);
        io_out_valid  = mfu_accept && (m_class == MC_IO_OUT);
        io_out_data   = io_out_valid ? m_data[IO_W-1:0] : '0;
        o_cdb_valid   = fifo_b_valid;
        o_cdb         = fifo_b_valid ? fifo_b_data : '0;
        push_data     = {push_tag_q,
                         push_ram_q ? ram_rdata : {{(DATA_W-IO_W){1'b0}}, push_io_q}};
    end

    fifo #(
        .FIFO_DEPTH_W ($clog2(RESP_DEPTH)),
        .DATA_W       (CDB_W)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .a_valid_i (push_vld_q),
        .a_data_i  (push_data),
        .a_ready_o (fifo_a_ready),
        .b_valid_o (fifo_b_valid),
        .b_data_o  (fifo_b_data),
        .b_ready_i (o_cdb_ready)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) push_vld_q |-> fifo_a_ready);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data RAM and the byte I/O channel between the instruction-fetch unit and memory_functional_unit (MFU).
- Issues RAM and I/O transactions and returns load/input results onto the CDB tagged with the requester's rsv_id.
- Returns fetch words to the fetch unit.
- Sits between the MFU's memory request port and the RAM/UART wrappers.

Parameters:
ADDR_W, 14, RAM word-address bits taken from request address [ADDR_W-1:0]
RESP_DEPTH, 2, CDB response buffer entries (credit limit for outstanding loads/inputs)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
f_valid  in  1  fetch request
f_address  in  DATA_W  fetch address
f_ready  out  1  fetch request granted this cycle
f_rdata_valid  out  1  fetch data valid (1 cycle after grant)
f_rdata  out  DATA_W  fetch data
m_valid  in  1  MFU request (MFU o_valid)
m_opcode  in  INSTR_W  MFU opcode
m_rsv_id  in  RSV_ID_W  MFU ROB tag
m_address  in  DATA_W  effective address
m_data  in  DATA_W  store/output data
m_ready  out  1  MFU request accepted (MFU o_ready)
o_cdb  out  CDB_W  {rsv_id, data}
o_cdb_valid  out  1  CDB result valid
o_cdb_ready  in  1  CDB accepts result
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, 1-cycle latency
io_in_valid  in  1  input byte available
io_in_data  in  8  input byte
io_in_ready  out  1  input byte consumed
io_out_valid  out  1  output byte valid
io_out_data  out  8  output byte (m_data[7:0])
io_out_ready  in  1  output sink ready

Behaviour:
- Reset (rst high at posedge): all outputs 0; response buffer empty; credit count 0; last_grant = FETCH; read pipeline flushed. Reset mid-transaction discards in-flight reads and buffered results; no CDB or fetch response is produced for them.
- Opcode classes (from fcpu_pkg):
  - RAM_LD: I_LOAD, I_LOADB, I_LOADR
  - RAM_ST: I_STORE, I_STOREB, I_STORER
  - IO_IN: I_INPUT
  - IO_OUT: I_OUTPUT
  - Any other opcode: m_ready = 1, request dropped, no side effect.
- MFU eligibility (combinational from registered state and inputs; must not depend on o_cdb_ready):
  - RAM_LD: credits available.
  - RAM_ST: always.
  - IO_IN: io_in_valid and credits available.
  - IO_OUT: io_out_ready.
- Credits: outstanding = RAM reads in flight + buffered results. Available when outstanding < RESP_DEPTH. A same-cycle CDB pop does not free a credit until the next cycle.
- RAM arbitration (RAM_LD, RAM_ST, fetch):
  - Only one requester needs RAM: it wins.
  - Both eligible: round-robin on last_grant. last_grant updates only on a contested grant.
  - IO_IN and IO_OUT never use RAM and proceed in parallel with a fetch grant.
- Grant actions:
  - Fetch: ram_en = 1, ram_we = 0, f_ready = 1; f_rdata_valid = 1 with ram_rdata next cycle. Fetch has no backpressure.
  - RAM_LD: ram_en = 1, ram_we = 0; tag registered; next cycle {tag, ram_rdata} enters the response buffer.
  - RAM_ST: ram_en = 1, ram_we = 1, ram_wdata = m_data. No CDB result.
  - IO_IN: io_in_ready = 1; {tag, zero-extended io_in_data} enters the response buffer next cycle.
  - IO_OUT: io_out_valid = 1, io_out_data = m_data[7:0]. No CDB result.
- Response buffer: FIFO, RESP_DEPTH entries. Head drives o_cdb / o_cdb_valid (registered, 0-latency from head). Pop on o_cdb_valid & o_cdb_ready.
- Simultaneous push and pop: both occur. The credit rule guarantees no overflow; overflow is an assertion failure.
- Ordering: CDB results leave in MFU acceptance order.
- Minimum load latency: accept at cycle N, o_cdb_valid at N+2.
- Address bits above ADDR_W are ignored.

Decomposition:
- fcpu_pkg gains:
  - typedef mem_class_t {MC_NONE, MC_RAM_LD, MC_RAM_ST, MC_IO_IN, MC_IO_OUT}
  - function mem_class(opcode)
  - localparam IO_W = 8
- Sub-module: reuse the existing fifo for the response buffer (FIFO_DEPTH_W = 1, DATA_W = CDB_W). Credits are tracked in mem_port_arbiter, not via fifo a_ready.

Test Plan:
- Fetch alone at addr 0x10, RAM[0x10] = 0xDEADBEEF -> f_ready same cycle; f_rdata_valid next cycle with 0xDEADBEEF; no CDB activity.
- MFU I_LOAD rsv 5, addr 0x20 (RAM = 0x1234) with o_cdb_ready = 1 -> o_cdb = {5, 0x1234} valid exactly 2 cycles after accept.
- Fetch and I_STORE both valid for 4 cycles -> grants alternate MFU, fetch, MFU, fetch, starting with MFU after reset; RAM writes land at the store address.
- o_cdb_ready = 0, three back-to-back I_LOADs (rsv 1, 2, 3) -> first two accepted, m_ready = 0 for rsv 3; raising o_cdb_ready drains {1}, {2}, then rsv 3 is accepted; order preserved.
- I_OUTPUT data 0x141 with io_out_ready = 0 for 3 cycles -> m_ready = 0 throughout; then io_out_valid = 1 with byte 0x41, m_ready = 1.
- I_INPUT rsv 7 with io_in_data = 0x5A, then rst asserted the following cycle -> no CDB output; all outputs 0; credits restored to RESP_DEPTH.
